mux_vector_sequencer: RTL and testbench

MUX_VECTOR_SEQUENCER -- requirements
Module: mux_vector_sequencer

---
 rtl/mux_vector_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mux_vector_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_vector_sequencer.sv
// Exhaustive stimulus sequencer for a 2:1 gate-level mux (z = c ? b : a).
// Walks the eight {a,b,c} combinations. After each vector it waits SETTLE
// cycles, samples z_in, and keeps pass/fail statistics for the run.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   start                - run request, sampled only while idle
//   z_in                 - mux output under test
//   a_out, b_out, c_out  - registered stimulus driven to the mux inputs
//   busy                 - high from start acceptance until the run ends
//   done                 - one-cycle pulse at the end of a run
//   pass_cnt, fail_cnt   - vectors passed / failed in the current or last run
//   fail_vec             - bit i set when vector i failed
//   all_pass             - last completed run had no failures
module mux_vector_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_cnt,
  output logic [3:0] fail_cnt,
  output logic [7:0] fail_vec,
  output logic       all_pass
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic               a_nxt, b_nxt, c_nxt;
  logic               busy_nxt, done_nxt, all_pass_nxt;
  logic [CNT_W-1:0]   pass_nxt, fail_nxt;
  logic [7:0]         fail_vec_nxt;
  logic               expected_c;
  logic               hit_c;

  // Reference mux on the currently driven stimulus; === so X/Z on z_in fails.
  assign expected_c = c_out ? b_out : a_out;
  assign hit_c      = (z_in === expected_c);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = (SETTLE == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (idx == IDX_W'(7)) ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    a_nxt          = a_out;
    b_nxt          = b_out;
    c_nxt          = c_out;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    pass_nxt       = pass_cnt;
    fail_nxt       = fail_cnt;
    fail_vec_nxt   = fail_vec;
    all_pass_nxt   = all_pass;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt      = '0;
          {a_nxt, b_nxt, c_nxt} = 3'b000;
          busy_nxt     = 1'b1;
          pass_nxt     = '0;
          fail_nxt     = '0;
          fail_vec_nxt = '0;
          all_pass_nxt = 1'b0;
        end
      end
      S_DRIVE: begin
        // Down-counter expires on its last SETTLE cycle.
        if (SETTLE != 0) settle_cnt_nxt = CNT_W'(SETTLE - 1);
      end
      S_SETTLE: begin
        if (settle_cnt != '0) settle_cnt_nxt = settle_cnt - CNT_W'(1);
      end
      S_CHECK: begin
        if (hit_c) begin
          pass_nxt = pass_cnt + CNT_W'(1);
        end else begin
          fail_nxt          = fail_cnt + CNT_W'(1);
          fail_vec_nxt[idx] = 1'b1;
        end
        if (idx == IDX_W'(7)) begin
          // Verdict uses the count including this last vector.
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          all_pass_nxt = (fail_nxt == '0);
        end else begin
          idx_nxt = idx + IDX_W'(1);
          {a_nxt, b_nxt, c_nxt} = idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        done_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      c_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_vec   <= '0;
      all_pass   <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      a_out      <= a_nxt;
      b_out      <= b_nxt;
      c_out      <= c_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass_cnt   <= pass_nxt;
      fail_cnt   <= fail_nxt;
      fail_vec   <= fail_vec_nxt;
      all_pass   <= all_pass_nxt;
    end
  end

endmodule

// File: tb/tb_mux_vector_sequencer.sv
// Directed bench for mux_vector_sequencer: one instance with SETTLE=2 and a
// selectable mux model, and one with SETTLE=0 for back-to-back runs.
module tb_mux_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0;
  logic       z_in, z_in0;
  logic       a_out, b_out, c_out, a0, b0, c0;
  logic       busy, done, all_pass, busy0, done0, all_pass0;
  logic [3:0] pass_cnt, fail_cnt, pass0, fail0;
  logic [7:0] fail_vec, fail_vec0;
  logic [1:0] zmode;
  logic       zx;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Mux model: 0 correct, 1 stuck at 0, 2 driven with zx (X where supported)
  always_comb begin
    case (zmode)
      2'd0:    z_in = c_out ? b_out : a_out;
      2'd1:    z_in = 1'b0;
      default: z_in = zx;
    endcase
  end
  assign z_in0 = c0 ? b0 : a0;

  mux_vector_sequencer #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .z_in(z_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_vec(fail_vec), .all_pass(all_pass)
  );

  mux_vector_sequencer #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .z_in(z_in0),
    .a_out(a0), .b_out(b0), .c_out(c0),
    .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0),
    .fail_vec(fail_vec0), .all_pass(all_pass0)
  );

  // Start a run (optionally re-pulsing start at cycle restart_at) and
  // return the number of edges from acceptance until done is seen.
  task automatic run_dut(input int restart_at, output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = (lat == restart_at);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a_out, b_out, c_out, busy, done, all_pass} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000000", {a_out, b_out, c_out, busy, done, all_pass});
    end
    vectors++;
    if ({pass_cnt, fail_cnt, fail_vec} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_counts got %h want 0000", {pass_cnt, fail_cnt, fail_vec});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct_run;
    int lat;
    zmode = 2'd0;
    run_dut(-1, lat);
    vectors++;
    if (lat !== 32) begin miscompares++; $display("FAIL correct_latency got %0d want 32", lat); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL correct_busy_in_done got %b want 0", busy); end
    vectors++;
    if ({pass_cnt, fail_cnt, fail_vec, all_pass} !== {4'd8, 4'd0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL correct_results got p=%0d f=%0d v=%h ap=%b want p=8 f=0 v=00 ap=1",
               pass_cnt, fail_cnt, fail_vec, all_pass);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if ({done, pass_cnt, all_pass, a_out, b_out, c_out} !== {1'b0, 4'd8, 1'b1, 3'b111}) begin
      miscompares++;
      $display("FAIL correct_hold got d=%b p=%0d ap=%b abc=%b%b%b want d=0 p=8 ap=1 abc=111",
               done, pass_cnt, all_pass, a_out, b_out, c_out);
    end
  endtask

  task automatic test_stuck_zero;
    int lat;
    zmode = 2'd1;
    run_dut(-1, lat);
    vectors++;
    if ({pass_cnt, fail_cnt, fail_vec, all_pass} !== {4'd4, 4'd4, 8'hD8, 1'b0}) begin
      miscompares++;
      $display("FAIL stuck0_results got p=%0d f=%0d v=%h ap=%b want p=4 f=4 v=d8 ap=0",
               pass_cnt, fail_cnt, fail_vec, all_pass);
    end
  endtask

  task automatic test_x_input;
    int lat;
    logic [7:0] exp_vec;
    logic [3:0] exp_fail;
    logic [2:0] v;
    logic m;
    zx = 1'bx;
    exp_vec = '0;
    exp_fail = '0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      m = v[0] ? v[1] : v[2];
      if (zx !== m) begin exp_vec[i] = 1'b1; exp_fail++; end
    end
    zmode = 2'd2;
    run_dut(-1, lat);
    vectors++;
    if ({fail_cnt, fail_vec, all_pass} !== {exp_fail, exp_vec, exp_fail == 4'd0}) begin
      miscompares++;
      $display("FAIL xin_results got f=%0d v=%h ap=%b want f=%0d v=%h ap=%b",
               fail_cnt, fail_vec, all_pass, exp_fail, exp_vec, exp_fail == 4'd0);
    end
    zmode = 2'd0;
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    int lat;
    zmode = 2'd0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    vectors++;
    if ({pass_cnt, a_out, b_out, c_out, busy} !== {4'd3, 3'b011, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_pre got p=%0d abc=%b%b%b busy=%b want p=3 abc=011 busy=1",
               pass_cnt, a_out, b_out, c_out, busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({a_out, b_out, c_out, busy, done, all_pass, pass_cnt, fail_cnt, fail_vec} !== 22'h0) begin
      miscompares++;
      $display("FAIL midrst_async got %h want 000000",
               {a_out, b_out, c_out, busy, done, all_pass, pass_cnt, fail_cnt, fail_vec});
    end
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    vectors++;
    if (ndone !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_nodone got done_pulses=%0d busy=%b want 0 0", ndone, busy);
    end
    run_dut(-1, lat);
    vectors++;
    if ({lat == 32, pass_cnt, fail_cnt} !== {1'b1, 4'd8, 4'd0}) begin
      miscompares++;
      $display("FAIL midrst_rerun got lat=%0d p=%0d f=%0d want lat=32 p=8 f=0", lat, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_start_mid_run;
    int lat;
    zmode = 2'd1;
    run_dut(10, lat);
    vectors++;
    if (lat !== 32) begin miscompares++; $display("FAIL midstart_latency got %0d want 32", lat); end
    vectors++;
    if ({pass_cnt, fail_cnt, fail_vec} !== {4'd4, 4'd4, 8'hD8}) begin
      miscompares++;
      $display("FAIL midstart_results got p=%0d f=%0d v=%h want p=4 f=4 v=d8", pass_cnt, fail_cnt, fail_vec);
    end
    zmode = 2'd0;
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk) start0 = 1'b1;
    n = 0;
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if ({done0, pass0, all_pass0} !== {1'b1, 4'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_first got d=%b p=%0d ap=%b want d=1 p=8 ap=1", done0, pass0, all_pass0);
    end
    @(negedge clk);
    vectors++;
    if ({done0, busy0, pass0} !== {1'b0, 1'b0, 4'd8}) begin
      miscompares++;
      $display("FAIL b2b_idle got d=%b busy=%b p=%0d want d=0 busy=0 p=8", done0, busy0, pass0);
    end
    @(negedge clk);
    vectors++;
    if ({busy0, pass0, all_pass0} !== {1'b1, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_clear got busy=%b p=%0d ap=%b want busy=1 p=0 ap=0", busy0, pass0, all_pass0);
    end
    n = 2;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done0) break;
    end
    vectors++;
    if (n !== 18) begin miscompares++; $display("FAIL b2b_period got %0d want 18", n); end
    start0 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    start  = 1'b0;
    start0 = 1'b0;
    zmode  = 2'd0;
    zx     = 1'b0;
    rst    = 1'b0;
    test_reset;
    test_correct_run;
    test_stuck_zero;
    test_x_input;
    test_reset_mid_run;
    test_start_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
